sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch master (inst_*) and the EX-stage data master (data_*).
- Arbitrates request handshakes (req/addr_ok) and tracks outstanding transactions in an in-order routing FIFO, so that each data_ok/rdata is returned to the master that issued the request.
- Sits between the pipeline stages and the SRAM-like-to-AXI bridge, and adds zero cycles to the request or response path.

Parameters:
- OST_DEPTH, 4, maximum accepted-but-unanswered transactions; must be a power of 2, at least 2.
- STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced to win; at least 1.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req  in  1  fetch request
inst_wr  in  1  fetch write flag (0 in normal use)
inst_size  in  2  00=byte, 01=half, 10=word
inst_wstrb  in  4  byte strobes
inst_addr  in  32  fetch address
inst_wdata  in  32  fetch write data
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid
inst_rdata  out  32  fetch read data
data_req  in  1  data request
data_wr  in  1  data write flag
data_size  in  2  data size
data_wstrb  in  4  data byte strobes
data_addr  in  32  data address
data_wdata  in  32  data write data
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data read data
mem_req  out  1  downstream request
mem_wr  out  1  downstream write flag
mem_size  out  2  downstream size
mem_wstrb  out  4  downstream strobes
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream write data
mem_addr_ok  in  1  downstream request accepted
mem_data_ok  in  1  downstream response valid; in order; one per accepted request, reads and writes alike
mem_rdata  in  32  downstream read data
protocol_err  out  1  sticky flag: mem_data_ok arrived with no transaction outstanding

Behaviour:
- Handshake: a request is accepted in a cycle where mem_req && mem_addr_ok. In that cycle exactly one of inst_addr_ok/data_addr_ok equals mem_addr_ok, namely the granted master's; the other is 0.
- Selection:
  - sel = lock_id if lock is set.
  - Otherwise sel = INST if inst_req && (!data_req || starve_cnt == STARVE_LIMIT).
  - Otherwise sel = DATA if data_req, else INST.
- mem_req = (sel master's req) && (count != OST_DEPTH). mem_wr/size/wstrb/addr/wdata are a combinational mux of the sel master's fields.
- Lock:
  - Set when mem_req && !mem_addr_ok; lock_id <= sel. This holds the downstream request stable until it is accepted.
  - Cleared on mem_addr_ok.
  - Also cleared when the locked master deasserts req (pipeline flush withdraws data_req); mem_req drops in that same cycle.
- Starvation counter (starve_cnt):
  - Increments on each accepted DATA grant while inst_req=1, saturating at STARVE_LIMIT.
  - Clears on any accepted INST grant, and in any cycle where inst_req=0.
- Routing FIFO:
  - OST_DEPTH entries of 1 bit (0=INST, 1=DATA), with head/tail pointers of log2(OST_DEPTH) bits that wrap, and a count of log2(OST_DEPTH)+1 bits.
  - Push sel on accept; pop on mem_data_ok.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: when count == OST_DEPTH, mem_req=0 and both addr_ok=0. A pop in that cycle does not permit a same-cycle accept; the accept is allowed the next cycle.
- Response routing (combinational):
  - inst_data_ok = mem_data_ok && count != 0 && head == INST; data_data_ok likewise for DATA.
  - Both rdata outputs always carry mem_rdata.
- Empty: mem_data_ok while count == 0 is ignored (no pop, no data_ok) and sets protocol_err. protocol_err clears only on reset.
- Reset:
  - FIFO empty, pointers 0, lock=0, starve_cnt=0, protocol_err=0.
  - Hence all handshake outputs are 0 while the req inputs are low.
  - Reset mid-transaction discards all routing state; the downstream bridge shall be reset in the same cycle.
- Latency: request path 0 cycles (combinational); response path 0 cycles; lock and FIFO state update on the clk edge.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0x1c000000, mem_addr_ok=1 in cycle 0; mem_data_ok=1 with rdata=0x02800000 in cycle 2 -> inst_addr_ok=1 in cycle 0, inst_data_ok=1 with rdata 0x02800000 in cycle 2, data_data_ok=0 throughout.
- Contention: inst_req and data_req both 1 with mem_addr_ok=1 -> data granted first (mem_addr = data_addr). With STARVE_LIMIT=4 and data_req held continuously, the 5th accepted grant goes to inst.
- Lock: data_req=1 with mem_addr_ok=0 for 3 cycles while inst_req rises in cycle 1 -> mem_addr stays = data_addr until accept in cycle 3. If data_req drops in cycle 2 instead, mem_req=0 that cycle and the inst request is granted in cycle 3.
- Full/ordering: issue 4 accepts (I, D, I, D) with no responses -> 5th request sees mem_req=0. Then 4 mem_data_ok pulses -> routed as inst, data, inst, data. Simultaneous push/pop at count=3 leaves count=3.
- Wrap-around: 10 back-to-back alternating transactions with a 1-cycle response -> pointers wrap and every response is routed correctly.
- Error/reset: mem_data_ok with an empty FIFO -> protocol_err=1 and stays 1 until reset; reset with 2 outstanding -> count=0 and protocol_err=0 in the next cycle.

Source files
------------

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter
// Description : Shares one SRAM-like memory port between the instruction
//               fetch master and the data master. Requests are arbitrated
//               combinationally, and an in-order routing FIFO sends each
//               response back to the master that issued the request.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int OST_DEPTH    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        protocol_err
);

    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int STW   = $clog2(STARVE_LIMIT + 1);

    // Master identifiers, also the value stored per routing FIFO entry
    localparam logic [0:0] c_INST = 1'b0;
    localparam logic [0:0] c_DATA = 1'b1;

    localparam logic [PTR_W:0] c_FULL       = (PTR_W + 1)'(OST_DEPTH);
    localparam logic [STW-1:0] c_STARVE_MAX = STW'(STARVE_LIMIT);

    logic                 r_lock;
    logic [0:0]           r_lock_id;
    logic [STW-1:0]       r_starve_cnt;
    logic [OST_DEPTH-1:0] r_route;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [PTR_W:0]       r_count;
    logic                 r_protocol_err;

    logic [0:0] w_sel;
    logic       w_sel_req;
    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_pop;
    logic [0:0] w_head_id;

    // Grant selection: a stalled request keeps its master until accepted or
    // withdrawn; otherwise data wins unless inst has waited too long.
    always_comb begin
        w_sel = c_INST;
        if (r_lock) begin
            w_sel = r_lock_id;
        end else if (inst_req && (!data_req || r_starve_cnt == c_STARVE_MAX)) begin
            w_sel = c_INST;
        end else if (data_req) begin
            w_sel = c_DATA;
        end else begin
            w_sel = c_INST;
        end
    end

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign w_sel_req = (w_sel == c_DATA) ? data_req : inst_req;

    // Downstream request path is a pure mux of the selected master
    assign mem_req   = w_sel_req && !w_full;
    assign mem_wr    = (w_sel == c_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (w_sel == c_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (w_sel == c_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (w_sel == c_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (w_sel == c_DATA) ? data_wdata : inst_wdata;

    assign w_accept  = mem_req && mem_addr_ok;
    assign w_pop     = mem_data_ok && !w_empty;
    assign w_head_id = r_route[r_head];

    assign inst_addr_ok = w_accept && (w_sel == c_INST);
    assign data_addr_ok = w_accept && (w_sel == c_DATA);

    // Responses are steered by the oldest outstanding entry
    assign inst_data_ok = w_pop && (w_head_id == c_INST);
    assign data_data_ok = w_pop && (w_head_id == c_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign protocol_err = r_protocol_err;

    // Lock holds the selected master while its request waits for addr_ok;
    // it falls away by itself once mem_req drops (accept, withdraw or full).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock    <= 1'b0;
            r_lock_id <= c_INST;
        end else begin
            r_lock    <= mem_req && !mem_addr_ok;
            r_lock_id <= w_sel;
        end
    end

    // Count data grants that overtook a waiting fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!inst_req) begin
            r_starve_cnt <= '0;
        end else if (w_accept && w_sel == c_INST) begin
            r_starve_cnt <= '0;
        end else if (w_accept && w_sel == c_DATA && r_starve_cnt != c_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + STW'(1);
        end
    end

    // Routing FIFO: push the granted master on accept, pop on each response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_route <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_route[r_tail] <= w_sel;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for a response that matches no outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_protocol_err <= 1'b0;
        end else if (mem_data_ok && w_empty) begin
            r_protocol_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
